// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter: request owner, return-pipe
// entry and the supported read-latency ceiling.
package mem_arb_pkg;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_LDR = 1'b1
    } owner_t;

    typedef struct packed {
        logic   valid;
        owner_t owner;
    } ret_ent_t;

    localparam int RD_LAT_MAX = 3;

endpackage

// File: rtl/rd_return_pipe.sv
// Read-return tracker: follows each issued read until its data comes back
// from memory and routes it to the requester that owns it.
// Ports:
//   i_clk, i_rst               clock, async active-high reset
//   i_push, i_owner            a read was granted this cycle, and by whom
//   i_mem_rdata                raw memory read data
//   o_cpu_rvalid/o_cpu_rdata   CPU read return (data held between pulses)
//   o_ldr_rvalid/o_ldr_rdata   loader read return (data held between pulses)
module rd_return_pipe
    import mem_arb_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_push,
    input  owner_t            i_owner,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_cpu_rvalid,
    output logic [DATA_W-1:0] o_cpu_rdata,
    output logic              o_ldr_rvalid,
    output logic [DATA_W-1:0] o_ldr_rdata
);

    // Entry k is live in cycle grant+1+k; the last stage lines up
    // with the memory data for that read.
    ret_ent_t [RD_LAT:0] pipe_q;
    ret_ent_t [RD_LAT:0] pipe_d;
    logic [DATA_W-1:0]   cpu_hold_q;
    logic [DATA_W-1:0]   ldr_hold_q;
    ret_ent_t            tail;
    logic                cpu_rv;
    logic                ldr_rv;

    always_comb begin
        pipe_d = {pipe_q[RD_LAT-1:0], ret_ent_t'{valid: i_push, owner: i_owner}};
    end

    assign tail   = pipe_q[RD_LAT];
    assign cpu_rv = tail.valid && (tail.owner == OWN_CPU);
    assign ldr_rv = tail.valid && (tail.owner == OWN_LDR);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pipe_q     <= '0;
            cpu_hold_q <= '0;
            ldr_hold_q <= '0;
        end else begin
            pipe_q <= pipe_d;
            if (cpu_rv) cpu_hold_q <= i_mem_rdata;
            if (ldr_rv) ldr_hold_q <= i_mem_rdata;
        end
    end

    // Data passes straight through on the return cycle, then is held.
    assign o_cpu_rvalid = cpu_rv;
    assign o_ldr_rvalid = ldr_rv;
    assign o_cpu_rdata  = cpu_rv ? i_mem_rdata : cpu_hold_q;
    assign o_ldr_rdata  = ldr_rv ? i_mem_rdata : ldr_hold_q;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single-port program/data memory between the CPU datapath
// and the loader/debug port; one access issued per cycle.
// Ports:
//   i_clk, i_rst                clock, async active-high reset
//   i_ldr_prio                  1 = loader fixed priority, 0 = round-robin
//   i_cpu_* / o_cpu_*           CPU request, grant pulse, read return
//   i_ldr_* / o_ldr_*           loader request, grant pulse, read return
//   o_mem_addr/wdata/we         registered memory command
//   i_mem_rdata                 memory read data, RD_LAT (1..3) after addr
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_ldr_prio,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic              o_cpu_gnt,
    output logic              o_cpu_rvalid,
    output logic [DATA_W-1:0] o_cpu_rdata,
    input  logic              i_ldr_req,
    input  logic              i_ldr_we,
    input  logic [ADDR_W-1:0] i_ldr_addr,
    input  logic [DATA_W-1:0] i_ldr_wdata,
    output logic              o_ldr_gnt,
    output logic              o_ldr_rvalid,
    output logic [DATA_W-1:0] o_ldr_rdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_mem_we,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    owner_t            last_q;
    owner_t            last_d;
    logic              cpu_gnt;
    logic              ldr_gnt;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] wdata_d;
    logic              we_q;
    logic              we_d;
    logic              rd_push;
    owner_t            rd_owner;

    // Last-winner state; LDR after reset so the CPU takes the first tie.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) last_q <= OWN_LDR;
        else       last_q <= last_d;
    end

    always_comb begin
        last_d = last_q;
        if (cpu_gnt)      last_d = OWN_CPU;
        else if (ldr_gnt) last_d = OWN_LDR;
    end

    // Grants are blocked while reset is asserted so every output is 0.
    always_comb begin
        cpu_gnt = 1'b0;
        ldr_gnt = 1'b0;
        if (!i_rst) begin
            if (i_cpu_req && i_ldr_req) begin
                if (i_ldr_prio || last_q == OWN_CPU) ldr_gnt = 1'b1;
                else                                 cpu_gnt = 1'b1;
            end else begin
                cpu_gnt = i_cpu_req;
                ldr_gnt = i_ldr_req;
            end
        end
    end

    // Issue registers: address/data hold when idle, write enable does not.
    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        if (cpu_gnt) begin
            addr_d  = i_cpu_addr;
            wdata_d = i_cpu_wdata;
            we_d    = i_cpu_we;
        end else if (ldr_gnt) begin
            addr_d  = i_ldr_addr;
            wdata_d = i_ldr_wdata;
            we_d    = i_ldr_we;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
        end
    end

    assign rd_push  = (cpu_gnt && !i_cpu_we) || (ldr_gnt && !i_ldr_we);
    assign rd_owner = ldr_gnt ? OWN_LDR : OWN_CPU;

    rd_return_pipe #(
        .RD_LAT (RD_LAT),
        .DATA_W (DATA_W)
    ) u_ret (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_push       (rd_push),
        .i_owner      (rd_owner),
        .i_mem_rdata  (i_mem_rdata),
        .o_cpu_rvalid (o_cpu_rvalid),
        .o_cpu_rdata  (o_cpu_rdata),
        .o_ldr_rvalid (o_ldr_rvalid),
        .o_ldr_rdata  (o_ldr_rdata)
    );

    assign o_cpu_gnt   = cpu_gnt;
    assign o_ldr_gnt   = ldr_gnt;
    assign o_mem_addr  = addr_q;
    assign o_mem_wdata = wdata_q;
    assign o_mem_we    = we_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: two instances (RD_LAT=1 and 3) share
// stimulus, each with its own memory model and expectation queues.
module tb_mem_arbiter;

    typedef struct {
        int         cyc;
        logic [7:0] d;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       prio;
    logic       cr, cw, lr, lw;
    logic [7:0] ca, cd, la, ld;

    logic       cg [2];
    logic       crv [2];
    logic [7:0] crd [2];
    logic       lg [2];
    logic       lrv [2];
    logic [7:0] lrd [2];
    logic [7:0] maddr [2];
    logic [7:0] mwd [2];
    logic       mwe [2];
    logic [7:0] mrd [2];

    logic [7:0] mem [2][256];
    logic [7:0] rdp [2][3];
    logic [7:0] ref_mem [256];
    logic       fill;

    int  cyc = 0;
    int  n_tot = 0;
    int  n_bad = 0;
    ev_t q [6][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1)) u_a (
        .i_clk(clk), .i_rst(rst), .i_ldr_prio(prio),
        .i_cpu_req(cr), .i_cpu_we(cw), .i_cpu_addr(ca), .i_cpu_wdata(cd),
        .o_cpu_gnt(cg[0]), .o_cpu_rvalid(crv[0]), .o_cpu_rdata(crd[0]),
        .i_ldr_req(lr), .i_ldr_we(lw), .i_ldr_addr(la), .i_ldr_wdata(ld),
        .o_ldr_gnt(lg[0]), .o_ldr_rvalid(lrv[0]), .o_ldr_rdata(lrd[0]),
        .o_mem_addr(maddr[0]), .o_mem_wdata(mwd[0]), .o_mem_we(mwe[0]),
        .i_mem_rdata(mrd[0])
    );

    mem_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(3)) u_b (
        .i_clk(clk), .i_rst(rst), .i_ldr_prio(prio),
        .i_cpu_req(cr), .i_cpu_we(cw), .i_cpu_addr(ca), .i_cpu_wdata(cd),
        .o_cpu_gnt(cg[1]), .o_cpu_rvalid(crv[1]), .o_cpu_rdata(crd[1]),
        .i_ldr_req(lr), .i_ldr_we(lw), .i_ldr_addr(la), .i_ldr_wdata(ld),
        .o_ldr_gnt(lg[1]), .o_ldr_rvalid(lrv[1]), .o_ldr_rdata(lrd[1]),
        .o_mem_addr(maddr[1]), .o_mem_wdata(mwd[1]), .o_mem_we(mwe[1]),
        .i_mem_rdata(mrd[1])
    );

    function automatic logic [7:0] init_val(input logic [7:0] a);
        return a + 8'h95;
    endfunction

    function automatic int lat(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    // Synchronous-read memories: data appears RD_LAT cycles after address.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (fill) begin
                for (int a = 0; a < 256; a++) mem[i][a] <= init_val(8'(a));
            end else if (mwe[i]) begin
                mem[i][maddr[i]] <= mwd[i];
            end
            rdp[i][0] <= mem[i][maddr[i]];
            rdp[i][1] <= rdp[i][0];
            rdp[i][2] <= rdp[i][1];
        end
    end
    assign mrd[0] = rdp[0][0];
    assign mrd[1] = rdp[1][2];

    task automatic fail(input string nm, input int act, input int exp);
        n_bad++;
        $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic chk(input int k, input logic v, input logic [7:0] d,
                       input string nm);
        ev_t e;
        while (q[k].size() > 0 && q[k][0].cyc < cyc) begin
            n_tot++;
            e = q[k].pop_front();
            fail({"missing ", nm}, 0, int'(e.d));
        end
        if (v) begin
            n_tot++;
            if (q[k].size() == 0 || q[k][0].cyc != cyc) begin
                fail({"unexpected ", nm}, int'(d), 0);
            end else begin
                e = q[k].pop_front();
                if (e.d !== d) fail(nm, int'(d), int'(e.d));
            end
        end
    endtask

    // Monitor: gnt code 1 = CPU, 2 = LDR, 3 = both (always wrong).
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk(i, cg[i] | lg[i], {6'b0, lg[i], cg[i]},
                (i == 0) ? "gnt_l1" : "gnt_l3");
            chk(2 + i, crv[i], crd[i], (i == 0) ? "cpu_rd_l1" : "cpu_rd_l3");
            chk(4 + i, lrv[i], lrd[i], (i == 0) ? "ldr_rd_l1" : "ldr_rd_l3");
        end
    end

    task automatic drv(input logic p,
                       input logic c_r, input logic c_w,
                       input logic [7:0] c_a, input logic [7:0] c_d,
                       input logic l_r, input logic l_w,
                       input logic [7:0] l_a, input logic [7:0] l_d,
                       input int win);
        logic       w;
        logic [7:0] a;
        logic [7:0] d;
        @(posedge clk);
        #1;
        prio = p;
        cr = c_r; cw = c_w; ca = c_a; cd = c_d;
        lr = l_r; lw = l_w; la = l_a; ld = l_d;
        if (win != 0) begin
            w = (win == 1) ? c_w : l_w;
            a = (win == 1) ? c_a : l_a;
            d = (win == 1) ? c_d : l_d;
            for (int i = 0; i < 2; i++) begin
                q[i].push_back('{cyc, 8'(win)});
                if (!w) q[((win == 1) ? 2 : 4) + i].push_back('{cyc + 1 + lat(i), ref_mem[a]});
            end
            if (w) ref_mem[a] = d;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_rst(input logic req_hi);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cr = req_hi; lr = req_hi;
        for (int k = 0; k < 6; k++) q[k].delete();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n_tot++;
            if ({cg[i], crv[i], crd[i], lg[i], lrv[i], lrd[i],
                 maddr[i], mwd[i], mwe[i]} !== '0)
                fail("reset_outputs", int'(crd[i]) | int'(lrd[i]) | int'(maddr[i]), 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        cr = 1'b0; lr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; fill = 1'b1; prio = 1'b0;
        cr = 0; cw = 0; ca = 0; cd = 0;
        lr = 0; lw = 0; la = 0; ld = 0;
        for (int a = 0; a < 256; a++) ref_mem[a] = init_val(8'(a));
        @(posedge clk);
        #1;
        fill = 1'b0;

        // Single CPU read of 0x10 (expects 0xA5)
        do_rst(0);
        drv(0, 1, 0, 8'h10, 0, 0, 0, 0, 0, 1);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n_tot++;
            if (maddr[i] !== 8'h10 || mwe[i] !== 1'b0)
                fail("issue_addr", int'(maddr[i]), 'h10);
        end
        idle(5);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n_tot++;
            if (crd[i] !== 8'hA5) fail("cpu_rdata_hold", int'(crd[i]), 'hA5);
            n_tot++;
            if (lrd[i] !== 8'h00 || lrv[i] !== 1'b0)
                fail("ldr_idle", int'(lrd[i]), 0);
        end

        // Round-robin with both requesting reads
        do_rst(0);
        begin
            int ci = 0;
            int li = 0;
            for (int k = 0; k < 6; k++) begin
                drv(0, 1, 0, 8'(8'h30 + ci), 0, 1, 0, 8'(8'h60 + li), 0,
                    (k % 2 == 0) ? 1 : 2);
                if (k % 2 == 0) ci++;
                else li++;
            end
        end
        idle(5);

        // Loader priority: 8 writes, then drop priority
        do_rst(0);
        for (int k = 0; k < 8; k++)
            drv(1, 1, 0, 8'h23, 0, 1, 1, 8'(8'h20 + k), 8'(k), 2);
        drv(0, 1, 0, 8'h23, 0, 1, 0, 8'h21, 0, 1);
        drv(0, 0, 0, 0, 0, 1, 0, 8'h21, 0, 2);
        idle(5);

        // Write then read same address back-to-back
        do_rst(0);
        drv(0, 1, 1, 8'h40, 8'h5A, 0, 0, 0, 0, 1);
        drv(0, 1, 0, 8'h40, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n_tot++;
            if (mwe[i] !== 1'b1 || maddr[i] !== 8'h40 || mwd[i] !== 8'h5A)
                fail("issue_write", int'(mwd[i]), 'h5A);
        end
        idle(5);

        // Reset while a loader read is in flight
        do_rst(0);
        drv(0, 0, 0, 0, 0, 1, 0, 8'h11, 0, 2);
        do_rst(1);
        drv(0, 1, 0, 8'h12, 0, 1, 0, 8'h13, 0, 1);
        drv(0, 0, 0, 0, 0, 1, 0, 8'h13, 0, 2);
        idle(6);

        // Three consecutive reads, alternating owner
        do_rst(0);
        drv(0, 1, 0, 8'h01, 0, 0, 0, 0, 0, 1);
        drv(0, 0, 0, 0, 0, 1, 0, 8'h02, 0, 2);
        drv(0, 1, 0, 8'h03, 0, 0, 0, 0, 0, 1);
        idle(6);

        for (int k = 0; k < 6; k++) begin
            n_tot++;
            if (q[k].size() != 0) fail("leftover_expect", q[k].size(), 0);
        end
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port 8-bit program/data memory between two requesters: the CPU datapath and a program-loader/debug port.
- Sits between data_path and memory in top.
- Round-robin or loader-priority arbitration, one access issued per cycle.
- Pipelined read-return tracking so back-to-back reads from either side are routed correctly.

Parameters:
- ADDR_W, 8, memory address width.
- DATA_W, 8, memory data width.
- RD_LAT, 1, memory read latency in cycles from registered address to valid i_mem_rdata; legal range 1..3.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_ldr_prio  in  1  1 = loader has fixed priority; 0 = round-robin.
- i_cpu_req  in  1  CPU access request; held with fields stable until o_cpu_gnt.
- i_cpu_we  in  1  1 = write, 0 = read.
- i_cpu_addr  in  ADDR_W  CPU address.
- i_cpu_wdata  in  DATA_W  CPU write data.
- o_cpu_gnt  out  1  one-cycle accept pulse.
- o_cpu_rvalid  out  1  CPU read data valid, one-cycle pulse.
- o_cpu_rdata  out  DATA_W  CPU read data.
- i_ldr_req, i_ldr_we, i_ldr_addr, i_ldr_wdata  in  1/1/ADDR_W/DATA_W  loader request; same rules as CPU.
- o_ldr_gnt, o_ldr_rvalid, o_ldr_rdata  out  1/1/DATA_W  loader responses; same rules as CPU.
- o_mem_addr  out  ADDR_W  registered memory address.
- o_mem_wdata  out  DATA_W  registered memory write data.
- o_mem_we  out  1  registered memory write enable.
- i_mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset (async, i_rst=1):
  - All outputs 0.
  - Last-winner register = LDR, so the CPU wins the first round-robin tie.
  - Return pipeline cleared; in-flight reads are discarded and never produce rvalid.
- Arbitration (combinational, cycle N):
  - Only CPU requesting -> CPU wins.
  - Only loader requesting -> loader wins.
  - Both requesting, i_ldr_prio=1 -> loader wins.
  - Both requesting, i_ldr_prio=0 -> the side that is not the last winner wins.
  - Winner's gnt=1 in cycle N; loser's gnt=0 and it keeps requesting.
  - Last-winner updates only on a grant.
- Issue:
  - Winner's addr/wdata/we are registered to o_mem_* at edge N->N+1.
  - No grant -> o_mem_we=0; o_mem_addr/o_mem_wdata hold.
  - At most one write per cycle; o_mem_we is never high without a grant in the previous cycle.
- Read return:
  - Shift register depth RD_LAT+1 of {valid, owner}.
  - Granted read enters at N; rvalid pulses for the owner in cycle N+1+RD_LAT.
  - rdata is i_mem_rdata registered? No: rdata = i_mem_rdata passed through in that cycle, also held in an output register until that owner's next rvalid.
  - Writes enter no entry and get no response beyond gnt.
- Throughput:
  - Grant possible every cycle; no bubbles between consecutive accesses.
  - Accesses reach memory in grant order, so a write followed by a read to the same address returns the new data.
- Fairness: with both requesting continuously and i_ldr_prio=0, grants alternate strictly CPU, LDR, CPU, ...
- Priority mode:
  - i_ldr_prio may change any cycle; it takes effect on the next arbitration.
  - With prio=1 the CPU may starve; that is intended (boot load, CPU held by control).
- Req dropped before gnt: legal; no access issued.
- Req high in the gnt cycle is consumed. Continuing high the next cycle is a new request.
- Reset mid-read: rvalid must not pulse after reset release for accesses granted before reset.

Decomposition:
- Package mem_arb_pkg:
  - typedef enum logic {OWN_CPU, OWN_LDR} owner_t.
  - Typedef for the return-pipe entry {valid, owner_t}.
  - Localparam RD_LAT_MAX=3.
- Sub-module rd_return_pipe (parameter RD_LAT): shift register plus output demux and rdata hold registers.
- Arbiter and issue registers stay in mem_arbiter.

Test Plan:
- Reset, then CPU read addr 0x10 with mem[0x10]=0xA5, RD_LAT=1 -> o_cpu_gnt at cycle 0, o_mem_addr=0x10 at cycle 1, o_cpu_rvalid with 0xA5 at cycle 2; loader outputs stay 0.
- Both request reads continuously, i_ldr_prio=0, for 6 cycles -> gnt sequence CPU, LDR, CPU, LDR, CPU, LDR; each rvalid lands on the correct owner RD_LAT+1 cycles later with the correct data.
- Both request, i_ldr_prio=1, loader writes 0x00..0x07 at addr 0x20..0x27 -> 8 consecutive ldr_gnt, zero cpu_gnt. Drop prio -> CPU granted next cycle; CPU readback of 0x23 = 0x03.
- CPU write 0x5A to 0x40, then read 0x40 the next cycle -> two back-to-back grants; read returns 0x5A.
- Loader read granted, i_rst pulsed high for 1 cycle before its return -> all outputs 0 during reset; no ldr_rvalid afterwards; first tie after reset goes to CPU.
- RD_LAT=3, CPU read, LDR read, CPU read on consecutive cycles -> rvalids at cycles 4, 5, 6 to CPU, LDR, CPU respectively.
